pe_result_writeback: RTL and testbench

Downstream stage of the 4-lane PE array. Captures 4-word vector results and 32-bit scalar (accumulator) results, queues them, and serialises them one word per cycle onto the result-memory write port at consecutive addresses. Tracks the STOP instruction and raises `done` once every captured result has been written.

---
 rtl/pe_result_writeback_if.sv | 13 +
 rtl/pe_result_writeback.sv | 128 ++++++++++++
 tb/tb_pe_result_writeback.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pe_result_writeback_if.sv
// Result-memory write port: one word per cycle, held until the memory signals ready.
interface pe_result_writeback_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;

    modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
    modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/pe_result_writeback.sv
// Queues vector/scalar PE results and serialises them onto the result-memory
// write port at consecutive addresses; raises done after STOP once drained.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_RUN   | accepting results, draining queue
//  S_DRAIN | STOP seen; new results dropped, waiting for queue to empty
//  S_DONE  | everything written; holds until rst
module pe_result_writeback #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vec_valid,
    input  logic [3:0][DATA_WIDTH-1:0] vec_data,
    input  logic                       scalar_valid,
    input  logic [DATA_WIDTH-1:0]      scalar_data,
    input  logic                       stop_in,
    pe_result_writeback_if.master      wr,
    output logic [ADDR_WIDTH:0]        word_count,
    output logic                       overflow,
    output logic                       done
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_next;

    logic [3:0][DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]     q_vec;
    logic [PW-1:0]              head_q, tail_q, head_next, tail_next, sca_slot;
    logic [CW-1:0]              count_q, count_next, kept, free;
    logic [1:0]                 widx_q, widx_next;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [ADDR_WIDTH:0]        wcount_q;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_next;
    logic                       we_q, overflow_q, done_q;
    logic                       write_done, retire, push_vec, push_sca, drop;

    always_comb begin
        write_done = we_q && wr.mem_ready;
        retire     = write_done && (!q_vec[head_q] || widx_q == 2'd3);
        free       = DEPTH_C - count_q + CW'(retire);
        push_vec   = (state_q == S_RUN) && vec_valid && (free >= CW'(1));
        // a same-cycle scalar queues behind the vector, so it needs a second slot
        push_sca   = (state_q == S_RUN) && scalar_valid &&
                     (free >= (vec_valid ? CW'(2) : CW'(1)));
        drop       = (vec_valid && !push_vec) || (scalar_valid && !push_sca);
        kept       = count_q - CW'(retire);
        count_next = kept + CW'(push_vec) + CW'(push_sca);
        head_next  = head_q + PW'(retire);
        tail_next  = tail_q + PW'(push_vec) + PW'(push_sca);
        sca_slot   = tail_q + PW'(push_vec);
        widx_next  = widx_q;
        if (write_done) widx_next = retire ? 2'd0 : widx_q + 2'd1;
        // output data is registered, so look ahead to next cycle's head word
        wdata_next = wdata_q;
        if (kept == '0) begin
            if (push_vec)      wdata_next = vec_data[0];
            else if (push_sca) wdata_next = scalar_data;
        end else begin
            wdata_next = q_data[head_next][widx_next];
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_RUN:   if (stop_in) state_next = S_DRAIN;
            S_DRAIN: if (count_q == '0) state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            addr_q     <= '0;
            wcount_q   <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_next;
            head_q     <= head_next;
            tail_q     <= tail_next;
            count_q    <= count_next;
            widx_q     <= widx_next;
            we_q       <= (count_next != '0);
            wdata_q    <= wdata_next;
            overflow_q <= overflow_q | drop;
            done_q     <= (state_next == S_DONE);
            if (write_done) begin
                addr_q <= addr_q + 1'b1;
                if (wcount_q != '1) wcount_q <= wcount_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push_vec) begin
            q_data[tail_q] <= vec_data;
            q_vec[tail_q]  <= 1'b1;
        end
        if (push_sca) begin
            q_data[sca_slot] <= {{(3*DATA_WIDTH){1'b0}}, scalar_data};
            q_vec[sca_slot]  <= 1'b0;
        end
    end

    assign wr.mem_we    = we_q;
    assign wr.mem_addr  = addr_q;
    assign wr.mem_wdata = wdata_q;
    assign word_count   = wcount_q;
    assign overflow     = overflow_q;
    assign done         = done_q;
endmodule

// File: tb/tb_pe_result_writeback.sv
// Directed bench for pe_result_writeback; a second instance with a 2-bit address checks wrap.
module tb_pe_result_writeback;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vec_valid = 1'b0;
    logic [3:0][31:0]  vec_data = '0;
    logic              scalar_valid = 1'b0;
    logic [31:0]       scalar_data = '0;
    logic              stop_in = 1'b0;
    logic              mem_ready = 1'b0;
    logic [10:0]       word_count;
    logic              overflow, done;
    logic [2:0]        word_count2;
    logic              overflow2, done2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] log_data[$];
    logic [9:0]  log_addr[$];
    int          log_cyc[$];
    logic [31:0] log2_data[$];
    logic [1:0]  log2_addr[$];

    pe_result_writeback_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) wr1 ();
    pe_result_writeback_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2))  wr2 ();
    assign wr1.mem_ready = mem_ready;
    assign wr2.mem_ready = mem_ready;

    pe_result_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .QUEUE_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .vec_valid(vec_valid), .vec_data(vec_data),
        .scalar_valid(scalar_valid), .scalar_data(scalar_data), .stop_in(stop_in),
        .wr(wr1), .word_count(word_count), .overflow(overflow), .done(done));

    pe_result_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .QUEUE_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .vec_valid(vec_valid), .vec_data(vec_data),
        .scalar_valid(scalar_valid), .scalar_data(scalar_data), .stop_in(stop_in),
        .wr(wr2), .word_count(word_count2), .overflow(overflow2), .done(done2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && wr1.mem_we && wr1.mem_ready) begin
            log_data.push_back(wr1.mem_wdata);
            log_addr.push_back(wr1.mem_addr);
            log_cyc.push_back(cyc);
        end
        if (!rst && wr2.mem_we && wr2.mem_ready) begin
            log2_data.push_back(wr2.mem_wdata);
            log2_addr.push_back(wr2.mem_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_data.delete(); log_addr.delete(); log_cyc.delete();
        log2_data.delete(); log2_addr.delete();
    endtask

    initial begin
        // reset state
        tick();
        do_reset();
        check("rst_we", wr1.mem_we, 0);
        check("rst_addr", wr1.mem_addr, 0);
        check("rst_wdata", wr1.mem_wdata, 0);
        check("rst_wcount", word_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", done, 0);

        // single vector
        mem_ready = 1'b1;
        vec_data = {32'd4, 32'd3, 32'd2, 32'd1};
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        check("t1_we_first", wr1.mem_we, 1);
        check("t1_wdata_first", wr1.mem_wdata, 1);
        repeat (5) tick();
        check("t1_nwrites", log_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_data", log_data[i], i + 1);
            check("t1_addr", log_addr[i], i);
        end
        check("t1_wcount", word_count, 4);
        check("t1_we_idle", wr1.mem_we, 0);

        // vector and scalar in the same cycle
        do_reset();
        vec_data = {32'd8, 32'd7, 32'd6, 32'd5};
        scalar_data = 32'h99;
        vec_valid = 1'b1;
        scalar_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        scalar_valid = 1'b0;
        repeat (7) tick();
        check("t2_nwrites", log_data.size(), 5);
        for (int i = 0; i < 4; i++) check("t2_vdata", log_data[i], i + 5);
        check("t2_sdata", log_data[4], 32'h99);
        check("t2_saddr", log_addr[4], 4);
        check("t2_no_bubble", log_cyc[4] - log_cyc[0], 4);
        check("t2_ovf", overflow, 0);
        check("t2_wcount", word_count, 5);

        // five vectors into a full queue while memory is stalled
        mem_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int l = 0; l < 4; l++) vec_data[l] = 32'h100 + 32'(16 * k + l);
            vec_valid = 1'b1;
            tick();
        end
        vec_valid = 1'b0;
        check("t3_ovf_set", overflow, 1);
        check("t3_we_stall", wr1.mem_we, 1);
        check("t3_wdata_stall", wr1.mem_wdata, 32'h100);
        mem_ready = 1'b1;
        repeat (20) tick();
        check("t3_nwrites", log_data.size(), 16);
        check("t3_wcount", word_count, 16);
        check("t3_ovf_sticky", overflow, 1);
        check("t3_mid_data", log_data[4], 32'h110);
        check("t3_last_data", log_data[15], 32'h133);
        check("t3_last_addr", log_addr[15], 15);

        // mem_ready toggling 1,0,0,1 during a vector
        do_reset();
        vec_data = {32'hD, 32'hC, 32'hB, 32'hA};
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        check("t4_wdata_a", wr1.mem_wdata, 32'hA);
        tick();
        mem_ready = 1'b0;
        check("t4_wdata_b", wr1.mem_wdata, 32'hB);
        check("t4_addr_b", wr1.mem_addr, 1);
        for (int s = 0; s < 2; s++) begin
            tick();
            check("t4_stall_we", wr1.mem_we, 1);
            check("t4_stall_data", wr1.mem_wdata, 32'hB);
            check("t4_stall_addr", wr1.mem_addr, 1);
        end
        mem_ready = 1'b1;
        repeat (4) tick();
        check("t4_nwrites", log_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t4_data", log_data[i], 32'hA + i);
            check("t4_addr", log_addr[i], i);
        end

        // two vectors; the 2-bit-address instance wraps and its 3-bit count saturates at 7
        do_reset();
        vec_data = {32'h13, 32'h12, 32'h11, 32'h10};
        vec_valid = 1'b1;
        tick();
        vec_data = {32'h23, 32'h22, 32'h21, 32'h20};
        tick();
        vec_valid = 1'b0;
        repeat (10) tick();
        check("t5_nwrites2", log2_data.size(), 8);
        for (int i = 0; i < 4; i++) begin
            check("t5_wrap_addr", log2_addr[4 + i], i);
            check("t5_wrap_data", log2_data[4 + i], 32'h20 + i);
        end
        check("t5_addr2_wrapped", wr2.mem_addr, 0);
        check("t5_wcount_wide", word_count, 8);
        check("t5_wcount2_sat", word_count2, 7);

        // stop together with a scalar
        do_reset();
        scalar_data = 32'h5;
        scalar_valid = 1'b1;
        stop_in = 1'b1;
        tick();
        scalar_valid = 1'b0;
        stop_in = 1'b0;
        check("t6_we", wr1.mem_we, 1);
        check("t6_wdata", wr1.mem_wdata, 32'h5);
        check("t6_done_early", done, 0);
        tick();
        check("t6_written", log_data.size(), 1);
        check("t6_done_not_yet", done, 0);
        tick();
        check("t6_done", done, 1);
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        repeat (3) tick();
        check("t6_late_we", wr1.mem_we, 0);
        check("t6_late_ovf", overflow, 1);
        check("t6_late_nwrites", log_data.size(), 1);
        check("t6_done_hold", done, 1);
        do_reset();
        check("t6_rst_we", wr1.mem_we, 0);
        check("t6_rst_addr", wr1.mem_addr, 0);
        check("t6_rst_wdata", wr1.mem_wdata, 0);
        check("t6_rst_wcount", word_count, 0);
        check("t6_rst_ovf", overflow, 0);
        check("t6_rst_done", done, 0);

        // reset discards queued data; stop with an empty queue
        mem_ready = 1'b0;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        do_reset();
        mem_ready = 1'b1;
        repeat (5) tick();
        check("t7_discard_writes", log_data.size(), 0);
        check("t7_discard_we", wr1.mem_we, 0);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        check("t7_done_t1", done, 0);
        tick();
        check("t7_done_t2", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
